n64_joybus_device: RTL and testbench
====================================

N64_JOYBUS_DEVICE -- requirements
Module: n64_joybus_device

Interface
REQ-001 SHALL provide parameter SPU, default 4, meaning sample_clk cycles per microsecond (legal range 2..16).
REQ-002 SHALL provide parameter RESP_GAP_US, default 2, meaning microseconds from the end of the console stop bit to the first response bit.
REQ-003 SHALL provide parameter IDLE_US, default 8, meaning continuous-high microseconds that abort a partial receive.
REQ-004 SHALL provide port sample_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL provide port data_rx, input, 1 bit: the joybus line level, asynchronous to sample_clk.
REQ-007 SHALL provide port button_state, input, 16 bits: the button bits, MSB first on the wire.
REQ-008 SHALL provide port stick_xy, input, 16 bits: [15:8] is signed X, [7:0] is signed Y.
REQ-009 SHALL provide port data_tx, output, 1 bit: the level to drive; 1 means release the line.
REQ-010 SHALL provide port cur_operation, output, 1 bit: 0 means RX, 1 means TX (line driven).
REQ-011 SHALL provide port cmd, output, 8 bits: the last received command byte.
REQ-012 SHALL provide port cmd_strobe, output, 1 bit: a one-cycle pulse when cmd updates.

Function
REQ-013 SHALL pass data_rx through a 2-flop synchroniser; all decoding uses the synchronised level, giving 2 cycles of input latency.
REQ-014 SHALL use the FSM states IDLE, RX_LOW, RX_HIGH, RX_STOP, GAP, TX_LOW, TX_HIGH, TX_STOP.
REQ-015 SHALL, in IDLE, move to RX_LOW on a synchronised falling edge and clear the sample counter.
REQ-016 SHALL decode each received bit from the line level sampled 2*SPU cycles after its falling edge (high = 1, low = 0), shifting the bits in MSB first.
REQ-017 SHALL, after 8 bits, treat the next falling edge as the console stop bit (RX_STOP), latch cmd, and pulse cmd_strobe on the cycle the line returns high.
REQ-018 SHALL decode the following commands:
- 0x00 → reply 0x05, 0x00, 0x02.
- 0x01 → reply button_state[15:8], button_state[7:0], stick_xy[15:8], stick_xy[7:0].
- 0xFF → per REQ-031.
- Any other value → no reply; return to IDLE.
REQ-019 SHALL snapshot button_state and stick_xy on the cmd_strobe cycle; input changes during TX do not alter the reply.
REQ-020 SHALL hold data_tx=1 in GAP for exactly RESP_GAP_US*SPU cycles, then enter TX.
REQ-021 SHALL send each TX bit as 4*SPU cycles: a 0 is 3*SPU low then SPU high; a 1 is SPU low then 3*SPU high.
REQ-022 SHALL end TX with a stop bit of 2*SPU low, then release, then return to IDLE.
REQ-023 SHALL keep cur_operation=1 from the first TX bit through the end of the stop bit, and 0 otherwise.
REQ-024 SHALL, if the line stays high for IDLE_US*SPU cycles with 1..7 bits received, discard those bits and return to IDLE.
REQ-025 SHALL ignore data_rx while in GAP or any TX state; no command is decoded during its own reply.
REQ-026 SHALL size its counters from SPU and IDLE_US, using no fixed widths.

Reset
REQ-027 SHALL, while reset=1, force state IDLE, data_tx=1, cur_operation=0, cmd=0x00, cmd_strobe=0, and clear the bit count and synchroniser.
REQ-028 SHALL, if reset is asserted mid-TX, release the line (data_tx=1) on the next edge; the partial reply is abandoned.
REQ-029 SHALL, after reset deasserts, accept a new command starting from the first subsequent falling edge.

Configuration
REQ-030 SHALL support the macro N64_RESET_CMD_EN.
REQ-031 SHALL, when N64_RESET_CMD_EN is defined, treat 0xFF like 0x00, replying 0x05, 0x00, 0x02, and pulsing cmd_strobe.
REQ-032 SHALL, when N64_RESET_CMD_EN is undefined, treat 0xFF as an unknown command: cmd_strobe pulses, with no reply.

Structure
REQ-033 SHALL place in package n64_pkg: the command codes (CMD_INFO, CMD_STATUS, CMD_RESET), the device ID bytes, the FSM state enum, and the reply length constants.
REQ-034 SHALL implement bit timing and shifting in sub-module n64_joybus_bit_tx, which takes SPU, a byte, and start/ready handshakes; the top-level FSM sequences the reply bytes.

Verification
REQ-035 SHALL cover these directed scenarios, with SPU=4:
- Command 0x01 with button_state=0x8001 and stick_xy=0x7F80 → after an 8-cycle gap, reply 80 01 7F 80 plus stop; cmd_strobe is one pulse; total TX is 32*16+8 cycles.
- Command 0x00 → reply 05 00 02; cur_operation is high for exactly 24*16+8 cycles.
- Command 0x55 → cmd=0x55 and cmd_strobe pulses; data_tx stays 1 and cur_operation stays 0.
- 5 bits, then 32 high cycles, then a full 0x01 → only the 0x01 is decoded and answered.
- Reset asserted on the 10th TX bit → data_tx=1 on the next edge, state IDLE, then a following 0x00 is answered.
- 0xFF with and without N64_RESET_CMD_EN → a 3-byte reply, or no reply, respectively.

Source files
------------

// File: rtl/n64_pkg.sv
// ---------------------------------------------------------------------------
// n64_pkg
// Shared definitions for the N64 joybus controller device:
//   - command codes understood by the device
//   - controller ID bytes returned for the info/reset command
//   - top-level FSM state encoding
//   - reply lengths in bytes
//   - imax() helper for sizing shared counters
// No ports (package).
// ---------------------------------------------------------------------------
package n64_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [7:0] ID_BYTE0 = 8'h05;
    localparam logic [7:0] ID_BYTE1 = 8'h00;
    localparam logic [7:0] ID_BYTE2 = 8'h02;

    localparam logic [2:0] INFO_REPLY_LEN   = 3'd3;
    localparam logic [2:0] STATUS_REPLY_LEN = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        RX_LOW,
        RX_HIGH,
        RX_STOP,
        GAP,
        TX_LOW,
        TX_HIGH,
        TX_STOP
    } state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/n64_joybus_bit_tx.sv
// ---------------------------------------------------------------------------
// n64_joybus_bit_tx
// Serialises one byte (MSB first) onto the joybus line, or a single stop bit.
// Each data bit is 4*SPU cycles: a 0 is 3*SPU low + SPU high, a 1 is SPU low
// + 3*SPU high. The stop bit is 2*SPU low, after which the line is released.
//
// Ports:
//   sample_clk  in   clock
//   reset       in   synchronous active-high reset (releases the line)
//   start       in   load byte_in (or a stop bit) when ready is high
//   stop_bit    in   with start: send a stop bit instead of a byte
//   byte_in     in   byte to send
//   ready       out  idle, or in the final cycle of the current byte/stop,
//                    so the next byte can follow with no gap
//   data_tx     out  registered line level, 1 = released
// ---------------------------------------------------------------------------
module n64_joybus_bit_tx #(
    parameter int SPU = 4
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop_bit,
    input  logic [7:0] byte_in,
    output logic       ready,
    output logic       data_tx
);

    localparam int BIT_CYC  = 4 * SPU;
    localparam int STOP_CYC = 2 * SPU;
    localparam int CNT_W    = $clog2(BIT_CYC);

    logic             busy_q, busy_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bits_q, bits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_tx_q, data_tx_d;
    logic [CNT_W-1:0] cnt_dec;
    logic             last_cycle;

    assign cnt_dec    = cnt_q - CNT_W'(1);
    assign last_cycle = busy_q && (cnt_q == '0) && (stop_q || (bits_q == 3'd0));
    assign ready      = !busy_q || last_cycle;
    assign data_tx    = data_tx_q;

    always_comb begin
        busy_d    = busy_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        bits_d    = bits_q;
        cnt_d     = cnt_q;
        data_tx_d = data_tx_q;
        if (start && ready) begin
            busy_d    = 1'b1;
            stop_d    = stop_bit;
            shift_d   = byte_in;
            bits_d    = 3'd7;
            cnt_d     = stop_bit ? CNT_W'(STOP_CYC - 1) : CNT_W'(BIT_CYC - 1);
            data_tx_d = 1'b0;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                if (stop_q || (bits_q == 3'd0)) begin
                    busy_d    = 1'b0;
                    stop_d    = 1'b0;
                    data_tx_d = 1'b1;
                end else begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bits_d    = bits_q - 3'd1;
                    cnt_d     = CNT_W'(BIT_CYC - 1);
                    data_tx_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_dec;
                // cnt counts down across the bit; the low phase is the top
                // SPU (for a 1) or 3*SPU (for a 0) counts.
                if (stop_q)
                    data_tx_d = 1'b0;
                else if (shift_q[7])
                    data_tx_d = !(cnt_dec >= CNT_W'(3 * SPU));
                else
                    data_tx_d = !(cnt_dec >= CNT_W'(SPU));
            end
        end
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            busy_q    <= 1'b0;
            stop_q    <= 1'b0;
            shift_q   <= 8'h00;
            bits_q    <= 3'd0;
            cnt_q     <= '0;
            data_tx_q <= 1'b1;
        end else begin
            busy_q    <= busy_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            bits_q    <= bits_d;
            cnt_q     <= cnt_d;
            data_tx_q <= data_tx_d;
        end
    end

endmodule

// File: rtl/n64_joybus_device.sv
// ---------------------------------------------------------------------------
// n64_joybus_device
// N64 controller side of the joybus: decodes a console command byte and
// sends the info or status reply after a fixed turnaround gap.
//
// Ports:
//   sample_clk     in   clock, SPU cycles per microsecond
//   reset          in   synchronous active-high reset
//   data_rx        in   joybus line level (asynchronous)
//   button_state   in   16 button bits, MSB first on the wire
//   stick_xy       in   [15:8] signed X, [7:0] signed Y
//   data_tx        out  line drive level, 1 = released
//   cur_operation  out  0 = receiving, 1 = driving the reply
//   cmd            out  last received command byte
//   cmd_strobe     out  one-cycle pulse when cmd updates
//
// Build option: define N64_RESET_CMD_EN to answer 0xFF like 0x00; otherwise
// 0xFF is strobed but not answered.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | line released, waiting for a falling edge
// RX_LOW  | counting to the mid-bit sample point of a command bit
// RX_HIGH | bit sampled, waiting for the next falling edge (or timeout)
// RX_STOP | 8 bits in, console stop bit low, waiting for the line to rise
// GAP     | turnaround delay before the reply
// TX_LOW  | reply bit, line currently driven low
// TX_HIGH | reply bit, line currently released
// TX_STOP | reply stop bit
// ---------------------------------------------------------------------------
module n64_joybus_device
    import n64_pkg::*;
#(
    parameter int SPU         = 4,
    parameter int RESP_GAP_US = 2,
    parameter int IDLE_US     = 8
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        data_rx,
    input  logic [15:0] button_state,
    input  logic [15:0] stick_xy,
    output logic        data_tx,
    output logic        cur_operation,
    output logic [7:0]  cmd,
    output logic        cmd_strobe
);

    localparam int RX_SAMPLE_CYC = 2 * SPU;
    localparam int GAP_CYC       = RESP_GAP_US * SPU;
    localparam int IDLE_CYC      = IDLE_US * SPU;
    localparam int TMR_MAX       = imax(RX_SAMPLE_CYC, GAP_CYC);
    localparam int TMR_W         = $clog2(TMR_MAX);
    localparam int IDLE_W        = $clog2(IDLE_CYC);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              line_prev_q, line_prev_d;
    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              cmd_strobe_q, cmd_strobe_d;
    logic              cur_op_q, cur_op_d;
    logic [31:0]       reply_q, reply_d;
    logic [2:0]        bytes_left_q, bytes_left_d;

    logic              fall;
    logic              tx_start;
    logic              tx_stop;
    logic [7:0]        tx_byte;
    logic              tx_ready;
    logic              tx_line;

    n64_joybus_bit_tx #(
        .SPU (SPU)
    ) u_bit_tx (
        .sample_clk (sample_clk),
        .reset      (reset),
        .start      (tx_start),
        .stop_bit   (tx_stop),
        .byte_in    (tx_byte),
        .ready      (tx_ready),
        .data_tx    (tx_line)
    );

    assign fall          = line_prev_q && !sync2_q;
    assign data_tx       = tx_line;
    assign cur_operation = cur_op_q;
    assign cmd           = cmd_q;
    assign cmd_strobe    = cmd_strobe_q;

    always_comb begin
        sync1_d      = data_rx;
        sync2_d      = sync1_q;
        line_prev_d  = sync2_q;
        state_d      = state_q;
        tmr_d        = tmr_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        cmd_d        = cmd_q;
        cmd_strobe_d = 1'b0;
        cur_op_d     = cur_op_q;
        reply_d      = reply_q;
        bytes_left_d = bytes_left_q;
        tx_start     = 1'b0;
        tx_stop      = 1'b0;
        tx_byte      = reply_q[31:24];

        // Continuous-high run length while a command is partially received.
        if ((state_q == RX_LOW || state_q == RX_HIGH) && sync2_q)
            idle_d = (idle_q != '0) ? idle_q - IDLE_W'(1) : idle_q;
        else
            idle_d = IDLE_W'(IDLE_CYC - 1);

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = RX_LOW;
                    tmr_d      = TMR_W'(RX_SAMPLE_CYC - 1);
                    bit_cnt_d  = 4'd0;
                    rx_shift_d = 8'h00;
                end
            end
            RX_LOW: begin
                if (tmr_q == '0) begin
                    rx_shift_d = {rx_shift_q[6:0], sync2_q};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    state_d    = RX_HIGH;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RX_HIGH: begin
                if (fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        state_d = RX_STOP;
                    end else begin
                        state_d = RX_LOW;
                        tmr_d   = TMR_W'(RX_SAMPLE_CYC - 1);
                    end
                end else if (sync2_q && (idle_q == '0)) begin
                    state_d   = IDLE;
                    bit_cnt_d = 4'd0;
                end
            end
            RX_STOP: begin
                if (sync2_q) begin
                    cmd_d        = rx_shift_q;
                    cmd_strobe_d = 1'b1;
                    bit_cnt_d    = 4'd0;
                    tmr_d        = TMR_W'(GAP_CYC - 1);
                    state_d      = IDLE;
                    case (rx_shift_q)
                        CMD_STATUS: begin
                            reply_d      = {button_state, stick_xy};
                            bytes_left_d = STATUS_REPLY_LEN;
                            state_d      = GAP;
                        end
`ifdef N64_RESET_CMD_EN
                        CMD_INFO, CMD_RESET: begin
`else
                        CMD_INFO: begin
`endif
                            reply_d      = {ID_BYTE0, ID_BYTE1, ID_BYTE2, 8'h00};
                            bytes_left_d = INFO_REPLY_LEN;
                            state_d      = GAP;
                        end
                        default: ;
                    endcase
                end
            end
            GAP: begin
                if (tmr_q == '0) begin
                    tx_start     = 1'b1;
                    reply_d      = {reply_q[23:0], 8'h00};
                    bytes_left_d = bytes_left_q - 3'd1;
                    cur_op_d     = 1'b1;
                    state_d      = TX_LOW;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            TX_LOW, TX_HIGH: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    state_d  = TX_LOW;
                    if (bytes_left_q != 3'd0) begin
                        reply_d      = {reply_q[23:0], 8'h00};
                        bytes_left_d = bytes_left_q - 3'd1;
                    end else begin
                        tx_stop = 1'b1;
                        state_d = TX_STOP;
                    end
                end else begin
                    state_d = tx_line ? TX_HIGH : TX_LOW;
                end
            end
            TX_STOP: begin
                if (tx_ready) begin
                    cur_op_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            line_prev_q  <= 1'b0;
            state_q      <= IDLE;
            tmr_q        <= '0;
            idle_q       <= IDLE_W'(IDLE_CYC - 1);
            bit_cnt_q    <= 4'd0;
            rx_shift_q   <= 8'h00;
            cmd_q        <= 8'h00;
            cmd_strobe_q <= 1'b0;
            cur_op_q     <= 1'b0;
            reply_q      <= 32'h0;
            bytes_left_q <= 3'd0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            line_prev_q  <= line_prev_d;
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            idle_q       <= idle_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            cmd_q        <= cmd_d;
            cmd_strobe_q <= cmd_strobe_d;
            cur_op_q     <= cur_op_d;
            reply_q      <= reply_d;
            bytes_left_q <= bytes_left_d;
        end
    end

endmodule

// File: tb/tb_n64_joybus_device.sv
// ---------------------------------------------------------------------------
// tb_n64_joybus_device
// Directed bench for n64_joybus_device at SPU=4. The console drives the line
// through a wired-AND with the device's data_tx; a negedge monitor decodes
// the device's reply bits, counts strobes, TX cycles and the turnaround gap.
// ---------------------------------------------------------------------------
module tb_n64_joybus_device;
    import n64_pkg::*;

    localparam int SPU = 4;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] btn;
        logic [15:0] stick;
        int          nbytes;
        logic [31:0] word;
        int          op_cycles;
    } vec_t;

    logic        sample_clk = 1'b0;
    logic        reset;
    logic        con;
    logic        data_rx;
    logic [15:0] button_state;
    logic [15:0] stick_xy;
    logic        data_tx;
    logic        cur_operation;
    logic [7:0]  cmd;
    logic        cmd_strobe;

    int tests = 0;
    int fails = 0;

    always #5 sample_clk = ~sample_clk;
    assign data_rx = con & data_tx;

    n64_joybus_device #(
        .SPU         (SPU),
        .RESP_GAP_US (2),
        .IDLE_US     (8)
    ) dut (
        .sample_clk    (sample_clk),
        .reset         (reset),
        .data_rx       (data_rx),
        .button_state  (button_state),
        .stick_xy      (stick_xy),
        .data_tx       (data_tx),
        .cur_operation (cur_operation),
        .cmd           (cmd),
        .cmd_strobe    (cmd_strobe)
    );

    // reply monitor
    logic        mon_clr = 1'b0;
    int          mon_strobes, mon_op, mon_low, mon_nbits, mon_nbytes;
    int          mon_stops, mon_bad, mon_gap, mon_gap_run;
    logic        mon_gap_armed;
    logic [7:0]  mon_byte;
    logic [31:0] mon_word;

    always @(negedge sample_clk) begin
        if (mon_clr) begin
            mon_strobes = 0; mon_op = 0; mon_low = 0; mon_nbits = 0;
            mon_nbytes = 0; mon_stops = 0; mon_bad = 0; mon_gap = -1;
            mon_gap_run = 0; mon_gap_armed = 1'b0; mon_byte = 8'h00;
            mon_word = 32'h0;
        end else begin
            if (cmd_strobe === 1'b1) begin
                mon_strobes++;
                mon_gap_run = 0;
                mon_gap_armed = 1'b1;
            end
            if (mon_gap_armed) begin
                if (data_tx === 1'b0) begin
                    mon_gap = mon_gap_run;
                    mon_gap_armed = 1'b0;
                end else begin
                    mon_gap_run++;
                end
            end
            if (cur_operation === 1'b1) mon_op++;
            if (data_tx === 1'b0) begin
                mon_low++;
            end else if (mon_low > 0) begin
                if (mon_low == SPU || mon_low == 3 * SPU) begin
                    mon_byte = {mon_byte[6:0], (mon_low == SPU)};
                    mon_nbits++;
                    if (mon_nbits % 8 == 0) begin
                        mon_word = {mon_word[23:0], mon_byte};
                        mon_nbytes++;
                    end
                end else if (mon_low == 2 * SPU) begin
                    mon_stops++;
                end else begin
                    mon_bad++;
                end
                mon_low = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sample_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        con = 1'b0;
        tick(b ? SPU : 3 * SPU);
        con = 1'b1;
        tick(b ? 3 * SPU : SPU);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
        con = 1'b0;
        tick(SPU);
        con = 1'b1;
    endtask

    task automatic send_and_check(input vec_t v, input string tag);
        int exp_stops;
        button_state = v.btn;
        stick_xy     = v.stick;
        clear_mon();
        send_cmd(v.cmd);
        for (int k = 0; k < 20 && mon_strobes == 0; k++) tick(1);
        // reply must come from the snapshot, not the live inputs
        button_state = ~v.btn;
        stick_xy     = ~v.stick;
        tick(600);
        exp_stops = (v.nbytes != 0) ? 1 : 0;
        check({tag, ".cmd"},     32'(cmd),         32'(v.cmd));
        check({tag, ".strobes"}, 32'(mon_strobes), 32'd1);
        check({tag, ".nbytes"},  32'(mon_nbytes),  32'(v.nbytes));
        check({tag, ".reply"},   mon_word,         v.word);
        check({tag, ".op_cyc"},  32'(mon_op),      32'(v.op_cycles));
        check({tag, ".stops"},   32'(mon_stops),   32'(exp_stops));
        check({tag, ".badbits"}, 32'(mon_bad),     32'd0);
        if (v.nbytes != 0) check({tag, ".gap"}, 32'(mon_gap), 32'd8);
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        vecs[0] = '{8'h01, 16'h8001, 16'h7F80, 4, 32'h80017F80, 520};
        vecs[1] = '{8'h00, 16'hFFFF, 16'hFFFF, 3, 32'h00050002, 392};
        vecs[2] = '{8'h55, 16'h1234, 16'h5678, 0, 32'h0,        0};
        vecs[3] = '{8'h01, 16'h1234, 16'hA55A, 4, 32'h1234A55A, 520};
`ifdef N64_RESET_CMD_EN
        vecs[4] = '{8'hFF, 16'h0000, 16'h0000, 3, 32'h00050002, 392};
`else
        vecs[4] = '{8'hFF, 16'h0000, 16'h0000, 0, 32'h0,        0};
`endif
        vecs[5] = '{8'h02, 16'h00FF, 16'hFF00, 0, 32'h0,        0};

        reset = 1'b1;
        con = 1'b1;
        button_state = 16'h0;
        stick_xy = 16'h0;
        tick(5);
        check("rst.data_tx", 32'(data_tx),       32'd1);
        check("rst.cur_op",  32'(cur_operation), 32'd0);
        check("rst.cmd",     32'(cmd),           32'd0);
        check("rst.strobe",  32'(cmd_strobe),    32'd0);
        reset = 1'b0;
        tick(5);

        for (int i = 0; i < 6; i++)
            send_and_check(vecs[i], $sformatf("vec%0d", i));

        // partial command abandoned by a long high period
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        tick(32);
        v = '{8'h01, 16'h00FF, 16'h0102, 4, 32'h00FF0102, 520};
        send_and_check(v, "partial");

        // reset while driving the 10th reply bit
        button_state = 16'h0;
        stick_xy = 16'h0;
        clear_mon();
        send_cmd(8'h00);
        for (int k = 0; k < 2000 && mon_nbits < 9; k++) tick(1);
        check("midrst.reach9", 32'(mon_nbits >= 9), 32'd1);
        for (int k = 0; k < 100 && data_tx !== 1'b0; k++) tick(1);
        check("midrst.bit10low", 32'(data_tx), 32'd0);
        reset = 1'b1;
        tick(1);
        check("midrst.data_tx", 32'(data_tx),       32'd1);
        check("midrst.cur_op",  32'(cur_operation), 32'd0);
        check("midrst.state",   32'(dut.state_q),   32'(IDLE));
        reset = 1'b0;
        tick(4);
        v = '{8'h00, 16'h0, 16'h0, 3, 32'h00050002, 392};
        send_and_check(v, "postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
